// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pipelined single-ported memory between the
// fetch port and the load/store port. One grant per cycle, data has priority
// unless fetch has been denied STARVE_MAX times in a row. A tag pipe aligned
// with the memory latency routes each read response back to its issuer and
// drops fetch responses that were issued before a flush.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [14:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [14:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,
    input  logic        flush,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        starved
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_FETCH,
        GNT_DATA
    } gnt_e;

    gnt_e          gnt_sel;
    logic          force_fetch;
    logic [CW-1:0] starve_cnt;
    logic          epoch;
    logic          next_epoch;

    // One entry per cycle: {valid, is_fetch, epoch}; index MEM_LAT-1 lines up with mem_rdata.
    logic [MEM_LAT-1:0] tag_v;
    logic [MEM_LAT-1:0] tag_f;
    logic [MEM_LAT-1:0] tag_e;

    logic        out_v;
    logic        out_f;
    logic        out_e;
    logic [15:0] if_hold;
    logic [15:0] d_hold;

    // Grant selection: data first, fetch forced once its denial count saturates.
    always_comb begin
        gnt_sel     = GNT_NONE;
        force_fetch = 1'b0;
        if (if_req && d_req) begin
            if (starve_cnt == SMAX) begin
                gnt_sel     = GNT_FETCH;
                force_fetch = 1'b1;
            end else begin
                gnt_sel = GNT_DATA;
            end
        end else if (d_req) begin
            gnt_sel = GNT_DATA;
        end else if (if_req) begin
            gnt_sel = GNT_FETCH;
        end
    end

    assign if_gnt  = (gnt_sel == GNT_FETCH);
    assign d_gnt   = (gnt_sel == GNT_DATA);
    assign starved = force_fetch;

    // Memory strobes, address and write data follow the granted port; idle drives zero.
    always_comb begin
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt_sel)
            GNT_FETCH: begin
                mem_ren  = 1'b1;
                mem_addr = if_addr;
            end
            GNT_DATA: begin
                mem_ren  = ~d_we;
                mem_wen  = d_we;
                mem_addr = d_addr;
                if (d_we) begin
                    mem_wdata = d_wdata;
                end
            end
            default: begin
            end
        endcase
    end

    // Consecutive fetch-denial counter, saturating at STARVE_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SMAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // A fetch granted alongside a flush belongs to the post-flush epoch.
    assign next_epoch = epoch ^ flush;

    // Epoch register and tag shift pipe, one push per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epoch <= 1'b0;
            tag_v <= '0;
            tag_f <= '0;
            tag_e <= '0;
        end else begin
            epoch    <= next_epoch;
            tag_v[0] <= mem_ren;
            tag_f[0] <= if_gnt;
            tag_e[0] <= next_epoch;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_f[i] <= tag_f[i-1];
                tag_e[i] <= tag_e[i-1];
            end
        end
    end

    assign out_v = tag_v[MEM_LAT-1];
    assign out_f = tag_f[MEM_LAT-1];
    assign out_e = tag_e[MEM_LAT-1];

    assign if_rvalid = out_v & out_f & (out_e == epoch);
    assign d_rvalid  = out_v & ~out_f;

    // Last delivered word per port, so rdata holds steady between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_hold <= '0;
            d_hold  <= '0;
        end else begin
            if (if_rvalid) begin
                if_hold <= mem_rdata;
            end
            if (d_rvalid) begin
                d_hold <= mem_rdata;
            end
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : if_hold;
    assign d_rdata  = d_rvalid  ? mem_rdata : d_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: pipelined memory model plus a response
// scoreboard per port; each scenario task checks grants/strobes inline.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [14:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [14:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        flush;
    logic        mem_ren;
    logic        mem_wen;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        starved;

    int total;
    int bad;
    int unsigned cyc;

    typedef struct {
        int unsigned due;
        logic [15:0] data;
    } rsp_t;

    rsp_t if_q[$];
    rsp_t d_q[$];

    logic [15:0] mem [0:32767];
    logic [15:0] rpipe [0:MEM_LAT-1];

    mem_port_arbiter #(
        .MEM_LAT(MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_gnt(if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_gnt(d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .flush(flush),
        .mem_ren(mem_ren),
        .mem_wen(mem_wen),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .starved(starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pipelined memory: write on the edge, read data appears MEM_LAT cycles after mem_ren.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        for (int i = MEM_LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
        rpipe[0] <= mem_ren ? mem[mem_addr] : 16'hDEAD;
    end
    assign mem_rdata = rpipe[MEM_LAT-1];

    // Scoreboard: compare every response cycle against the expected queues.
    always @(negedge clk) begin
        logic exp_if;
        logic exp_d;
        while (if_q.size() > 0 && if_q[0].due < cyc) begin
            total++; bad++;
            $display("FAIL if_missing: due=%0d now=%0d exp_data=%h", if_q[0].due, cyc, if_q[0].data);
            void'(if_q.pop_front());
        end
        while (d_q.size() > 0 && d_q[0].due < cyc) begin
            total++; bad++;
            $display("FAIL d_missing: due=%0d now=%0d exp_data=%h", d_q[0].due, cyc, d_q[0].data);
            void'(d_q.pop_front());
        end
        exp_if = (if_q.size() > 0 && if_q[0].due == cyc);
        exp_d  = (d_q.size() > 0 && d_q[0].due == cyc);
        total++;
        if (if_rvalid !== exp_if) begin
            bad++;
            $display("FAIL if_rvalid cyc=%0d: got=%b exp=%b", cyc, if_rvalid, exp_if);
        end else if (exp_if) begin
            total++;
            if (if_rdata !== if_q[0].data) begin
                bad++;
                $display("FAIL if_rdata cyc=%0d: got=%h exp=%h", cyc, if_rdata, if_q[0].data);
            end
        end
        if (exp_if) void'(if_q.pop_front());
        total++;
        if (d_rvalid !== exp_d) begin
            bad++;
            $display("FAIL d_rvalid cyc=%0d: got=%b exp=%b", cyc, d_rvalid, exp_d);
        end else if (exp_d) begin
            total++;
            if (d_rdata !== d_q[0].data) begin
                bad++;
                $display("FAIL d_rdata cyc=%0d: got=%h exp=%h", cyc, d_rdata, d_q[0].data);
            end
        end
        if (exp_d) void'(d_q.pop_front());
    end

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        flush   = 1'b0;
    endtask

    // Waits (bounded) for outstanding responses, then a few quiet cycles.
    task automatic drain();
        for (int i = 0; i < 20 && (if_q.size() > 0 || d_q.size() > 0); i++) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
        end
        repeat (3) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        if_q.delete();
        d_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({if_rvalid, d_rvalid, starved} !== 3'b000) begin
            bad++;
            $display("FAIL reset_valids: got=%b exp=000", {if_rvalid, d_rvalid, starved});
        end
        total++;
        if (if_rdata !== 16'h0000 || d_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL reset_rdata: got=%h/%h exp=0000/0000", if_rdata, d_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({mem_ren, mem_wen, if_gnt, d_gnt, starved} !== 5'b0 || mem_addr !== 15'h0) begin
                bad++;
                $display("FAIL idle_strobes cyc=%0d: got=%b addr=%h exp=00000 addr=0000",
                         cyc, {mem_ren, mem_wen, if_gnt, d_gnt, starved}, mem_addr);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_stream();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            idle_inputs();
            if_req  = 1'b1;
            if_addr = 15'(k);
            if_q.push_back('{due: cyc + MEM_LAT, data: 16'h1000 + 16'(k)});
            @(negedge clk);
            total++;
            if ({if_gnt, d_gnt, mem_ren, mem_wen} !== 4'b1010 || mem_addr !== 15'(k)) begin
                bad++;
                $display("FAIL fetch_grant k=%0d: got=%b addr=%h exp=1010 addr=%h",
                         k, {if_gnt, d_gnt, mem_ren, mem_wen}, mem_addr, 15'(k));
            end
        end
        drain();
        total++;
        if (if_q.size() != 0 || d_q.size() != 0) begin
            bad++;
            $display("FAIL fetch_drain: got=%0d/%0d left exp=0/0", if_q.size(), d_q.size());
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 8; i++) begin
            logic exp_f;
            logic [14:0] fa;
            logic [14:0] da;
            exp_f = ((i % 4) == 3);
            fa = 15'h0010 + 15'(i);
            da = 15'h0020 + 15'(i);
            @(posedge clk); #1;
            idle_inputs();
            if_req  = 1'b1;
            if_addr = fa;
            d_req   = 1'b1;
            d_addr  = da;
            if (exp_f) if_q.push_back('{due: cyc + MEM_LAT, data: 16'h1000 + 16'(fa)});
            else       d_q.push_back('{due: cyc + MEM_LAT, data: 16'h1000 + 16'(da)});
            @(negedge clk);
            total++;
            if ({if_gnt, d_gnt, starved} !== {exp_f, ~exp_f, exp_f}) begin
                bad++;
                $display("FAIL contention_grant i=%0d: got=%b exp=%b",
                         i, {if_gnt, d_gnt, starved}, {exp_f, ~exp_f, exp_f});
            end
            total++;
            if (mem_addr !== (exp_f ? fa : da) || mem_ren !== 1'b1) begin
                bad++;
                $display("FAIL contention_addr i=%0d: got=%h ren=%b exp=%h ren=1",
                         i, mem_addr, mem_ren, exp_f ? fa : da);
            end
        end
        drain();
        total++;
        if (if_q.size() != 0 || d_q.size() != 0) begin
            bad++;
            $display("FAIL contention_drain: got=%0d/%0d left exp=0/0", if_q.size(), d_q.size());
        end
    endtask

    task automatic test_store_load();
        @(posedge clk); #1;
        idle_inputs();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 15'h0040;
        d_wdata = 16'hBEEF;
        @(negedge clk);
        total++;
        if ({d_gnt, mem_wen, mem_ren} !== 3'b110 || mem_addr !== 15'h0040 || mem_wdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL store_strobe: got=%b addr=%h wdata=%h exp=110 addr=0040 wdata=beef",
                     {d_gnt, mem_wen, mem_ren}, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        idle_inputs();
        d_req   = 1'b1;
        d_addr  = 15'h0040;
        d_wdata = 16'h1234;
        d_q.push_back('{due: cyc + MEM_LAT, data: 16'hBEEF});
        @(negedge clk);
        total++;
        if ({d_gnt, mem_wen, mem_ren} !== 3'b101 || mem_wdata !== 16'h0000) begin
            bad++;
            $display("FAIL load_strobe: got=%b wdata=%h exp=101 wdata=0000",
                     {d_gnt, mem_wen, mem_ren}, mem_wdata);
        end
        drain();
        total++;
        if (d_q.size() != 0) begin
            bad++;
            $display("FAIL store_load_drain: got=%0d left exp=0", d_q.size());
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            if_req  = 1'b1;
            if_addr = 15'h0100 + 15'(c);
            flush   = (c == 1);
            if (c != 0) if_q.push_back('{due: cyc + MEM_LAT, data: 16'h1100 + 16'(c)});
            @(negedge clk);
            total++;
            if (if_gnt !== 1'b1) begin
                bad++;
                $display("FAIL flush_grant c=%0d: got=%b exp=1", c, if_gnt);
            end
        end
        drain();
        total++;
        if (if_q.size() != 0) begin
            bad++;
            $display("FAIL flush_drain: got=%0d left exp=0", if_q.size());
        end
    endtask

    task automatic test_reset_midop();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            d_req  = 1'b1;
            d_addr = 15'h0200 + 15'(c);
            d_q.push_back('{due: cyc + MEM_LAT, data: 16'h1200 + 16'(c)});
            @(negedge clk);
        end
        @(posedge clk); #1;
        idle_inputs();
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 16'h1200) begin
            bad++;
            $display("FAIL midop_first_rsp: got=%b/%h exp=1/1200", d_rvalid, d_rdata);
        end
        if_q.delete();
        d_q.delete();
        rst_n = 1'b0;
        #1;
        total++;
        if (d_rvalid !== 1'b0 || d_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL midop_async_drop: got=%b/%h exp=0/0000", d_rvalid, d_rdata);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        d_req  = 1'b1;
        d_addr = 15'h0300;
        d_q.push_back('{due: cyc + MEM_LAT, data: 16'h1300});
        @(negedge clk);
        total++;
        if (d_gnt !== 1'b1 || mem_ren !== 1'b1 || mem_addr !== 15'h0300) begin
            bad++;
            $display("FAIL midop_first_grant: got=%b%b addr=%h exp=11 addr=0300", d_gnt, mem_ren, mem_addr);
        end
        drain();
        total++;
        if (d_q.size() != 0) begin
            bad++;
            $display("FAIL midop_drain: got=%0d left exp=0", d_q.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < 32768; i++) mem[i] = 16'h1000 + 16'(i);
        for (int i = 0; i < MEM_LAT; i++) rpipe[i] = 16'hDEAD;
        test_reset();
        test_fetch_stream();
        test_contention();
        test_store_load();
        test_flush();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, pipelined instruction/data memory between the CPU fetch stage (instruction port) and the load/store stage (data port).
- Grants at most one memory access per cycle and tracks in-flight reads so each response returns to the port that issued it.
- Suppresses stale fetch responses on a pipeline flush.
- Sits between the CPU pipeline and the memory model, replacing the dual read ports with one shared port.

Parameters:
MEM_LAT, 2, cycles from an issued read to mem_rdata valid (1..4).
STARVE_MAX, 3, consecutive fetch denials before fetch is forced to win.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request
if_addr  in  15  fetch word address [15:1]
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch data valid
if_rdata  out  16  fetch data
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_addr  in  15  data word address [15:1]
d_wdata  in  16  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid
d_rdata  out  16  load data
flush  in  1  pipeline flush; discard in-flight fetch responses
mem_ren  out  1  memory read strobe
mem_wen  out  1  memory write strobe
mem_addr  out  15  memory word address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data, MEM_LAT cycles after mem_ren
starved  out  1  forced-fetch cycle indicator (debug)

Behaviour:
- Reset (rst_n low, asynchronous): starve_cnt=0; tag pipe cleared. Registered outputs if_rvalid, d_rvalid and starved are 0. if_rdata and d_rdata are 16'h0000. Reset dominates every other input. Any responses in flight are lost and must never appear after reset is released.
- Grant logic is combinational, in the same cycle as the request:
  - Only data requests: d_gnt=1.
  - Only fetch requests: if_gnt=1.
  - Both requesting, starve_cnt < STARVE_MAX: data wins, if_gnt=0.
  - Both requesting, starve_cnt == STARVE_MAX: fetch wins, d_gnt=0, starved=1.
  - if_gnt and d_gnt are never both 1.
- Memory drive: mem_addr, mem_ren and mem_wen come from the granted port.
  - mem_ren = granted & (fetch | load).
  - mem_wen = granted store. mem_wdata = d_wdata when mem_wen=1, else 0.
  - With no grant, mem_ren=mem_wen=0 and mem_addr=0.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, when if_req=1 and if_gnt=0.
  - Resets to 0 on if_gnt=1, or when if_req=0.
- Tag pipe: a MEM_LAT-deep shift register of {valid, is_fetch, epoch}, pushed every cycle (valid = mem_ren).
  - When the entry emerges: if is_fetch, if_rvalid=1 and if_rdata=mem_rdata; otherwise d_rvalid=1 and d_rdata=mem_rdata.
  - The rdata outputs hold their last value when rvalid=0.
  - Each response is 1 cycle wide; responses are in order, one per cycle maximum.
  - Stores push valid=0 and produce no response.
- Flush:
  - A 1-bit epoch toggles on each cycle flush=1.
  - A fetch response whose epoch differs from the current epoch is dropped (if_rvalid=0).
  - A fetch granted in the same cycle as flush=1 is tagged with the new epoch and is kept.
  - Load responses are never dropped.
  - If flush is asserted in consecutive cycles, each assertion toggles the epoch. An in-flight fetch is kept only if the number of toggles since its issue is even. Callers must pulse flush once per redirect.
- Ordering:
  - A store issued in cycle N is visible to any read issued in cycle N+1 or later; the memory model must write before reading on the same edge.
  - The arbiter keeps no store buffer.
- Throughput: one access per cycle. Either port sees full bandwidth when the other is idle.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, release with no requests -> all outputs 0; mem_ren=mem_wen=0 for 10 cycles.
- Fetch stream, MEM_LAT=2: if_req=1 at addresses 0x0000..0x0003 for 4 cycles, memory word k = 0x1000+k.
  - Required: if_gnt=1 each cycle.
  - Required: if_rvalid high on cycles 2..5 with if_rdata 0x1000..0x1003; d_rvalid stays 0.
- Contention/starvation, STARVE_MAX=3: both ports request continuously for 8 cycles (d_we=0).
  - Required grant pattern: D,D,D,F,D,D,D,F.
  - Required: starved=1 only on the F cycles; responses are routed to the matching port in the same order.
- Store then load: store 0xBEEF to address 0x0040, then load 0x0040 the next cycle.
  - Required: mem_wen=1 for one cycle, no response for the store.
  - Required: d_rvalid=1 with d_rdata=0xBEEF two cycles after the load grant.
- Flush: issue fetches at cycles 0 and 1, pulse flush at cycle 1, issue a fetch at cycle 2.
  - Required: the cycle-0 response is dropped.
  - Required: the cycle-1 and cycle-2 responses are delivered (cycle 1 was granted with the flush) with correct data.
- Reset mid-operation: assert rst_n=0 while 2 loads are in flight.
  - Required: d_rvalid drops immediately and no response appears after release.
  - Required: the first request after release is granted in its own cycle.
